// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache; optional hit/miss counters under DCACHE_STATS_EN.
// Load hits return data combinationally; a load miss or any store holds stall high until mem_ack completes it.
module data_cache #(
    parameter int XLEN  = 32,
    parameter int LINES = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    input  logic            cpu_rd,
    input  logic            cpu_wr,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            stall,
    output logic            fill_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = XLEN - IDX - 2;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [XLEN-1:0]   data_q [LINES];

    logic [IDX-1:0]    req_idx, fill_idx, line_idx;
    logic [TAGW-1:0]   req_tag, fill_tag, line_tag;
    logic [XLEN-1:0]   line_data, rdata_c;
    logic              hit, line_we, stall_c, fill_c, req_c, we_c;
    logic              hit_evt, miss_evt;
    logic [1:0]        unused_byte_offset;

    assign req_idx  = cpu_addr[IDX+1:2];
    assign req_tag  = cpu_addr[XLEN-1:IDX+2];
    assign fill_idx = addr_q[IDX+1:2];
    assign fill_tag = addr_q[XLEN-1:IDX+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_byte_offset = cpu_addr[1:0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = valid_q;
        line_we   = 1'b0;
        line_idx  = req_idx;
        line_tag  = req_tag;
        line_data = cpu_wdata;
        stall_c   = 1'b0;
        fill_c    = 1'b0;
        rdata_c   = '0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous load and store is serviced as the store alone.
                if (cpu_wr) begin
                    stall_c = 1'b1;
                    addr_d  = {cpu_addr[XLEN-1:2], 2'b00};
                    wdata_d = cpu_wdata;
                    line_we = hit;
                    state_d = WRITE_THRU;
                end else if (cpu_rd) begin
                    if (hit) begin
                        rdata_c = data_q[req_idx];
                        hit_evt = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        addr_d   = {cpu_addr[XLEN-1:2], 2'b00};
                        miss_evt = 1'b1;
                        state_d  = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                req_c   = 1'b1;
                stall_c = !mem_ack;
                if (mem_ack) begin
                    fill_c            = 1'b1;
                    rdata_c           = mem_rdata;
                    line_we           = 1'b1;
                    line_idx          = fill_idx;
                    line_tag          = fill_tag;
                    line_data         = mem_rdata;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            WRITE_THRU: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                stall_c = !mem_ack;
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
    end

    // Reset forces IDLE, so only the IDLE stall path needs masking while rst_b is high.
    assign stall     = stall_c && !rst_b;
    assign fill_we   = fill_c;
    assign cpu_rdata = rdata_c;
    assign mem_req   = req_c;
    assign mem_we    = we_c;
    assign mem_addr  = req_c ? addr_q : '0;
    assign mem_wdata = we_c ? wdata_q : '0;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
        if (miss_evt && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_evt ^ miss_evt;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: miss/fill timing, write-through, no-allocate, eviction, reset abort, counters.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall, fill_we, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    data_cache #(.XLEN(32), .LINES(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .stall(stall), .fill_we(fill_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        logic [31:0] eh, em;
`ifdef DCACHE_STATS_EN
        eh = exp_hit;
        em = exp_miss;
`else
        eh = 0;
        em = 0;
`endif
        check({tag, "_hit_count"}, {16'h0, hit_count}, eh);
        check({tag, "_miss_count"}, {16'h0, miss_count}, em);
    endtask

    // Entered 1 time unit after a rising edge with the cache idle; returns the same way.
    task automatic load_miss(input logic [31:0] addr, input int lat, input logic [31:0] data);
        cpu_rd = 1'b1; cpu_addr = addr;
        #1 check("miss_stall_first", stall, 1);
        check("miss_no_req_first", mem_req, 0);
        for (int i = 1; i < lat; i++) begin
            tick();
            #1 check("miss_stall_wait", stall, 1);
            check("miss_req_wait", mem_req, 1);
            check("miss_we_wait", mem_we, 0);
            check("miss_addr_wait", mem_addr, {addr[31:2], 2'b00});
            check("miss_no_fill_wait", fill_we, 0);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = data;
        #1 check("ack_stall", stall, 0);
        check("ack_fill_we", fill_we, 1);
        check("ack_rdata", cpu_rdata, data);
        check("ack_req", mem_req, 1);
        check("ack_addr", mem_addr, {addr[31:2], 2'b00});
        tick();
        mem_ack = 1'b0; cpu_rd = 1'b0;
        exp_miss++;
    endtask

    task automatic load_hit(input logic [31:0] addr, input logic [31:0] data);
        cpu_rd = 1'b1; cpu_addr = addr;
        #1 check("hit_stall", stall, 0);
        check("hit_rdata", cpu_rdata, data);
        check("hit_no_req", mem_req, 0);
        check("hit_no_fill", fill_we, 0);
        tick();
        cpu_rd = 1'b0;
        exp_hit++;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input int lat, input logic with_rd);
        cpu_wr = 1'b1; cpu_rd = with_rd; cpu_addr = addr; cpu_wdata = data;
        #1 check("st_stall_first", stall, 1);
        check("st_rdata_zero", cpu_rdata, 0);
        for (int i = 1; i < lat; i++) begin
            tick();
            #1 check("st_stall_wait", stall, 1);
            check("st_req_wait", mem_req, 1);
            check("st_we_wait", mem_we, 1);
            check("st_addr_wait", mem_addr, {addr[31:2], 2'b00});
            check("st_wdata_wait", mem_wdata, data);
        end
        tick();
        mem_ack = 1'b1;
        #1 check("st_ack_stall", stall, 0);
        check("st_ack_we", mem_we, 1);
        check("st_ack_addr", mem_addr, {addr[31:2], 2'b00});
        check("st_ack_no_fill", fill_we, 0);
        tick();
        mem_ack = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    initial begin
        // Reset, with a load request presented to confirm reset masks it.
        cpu_rd = 1'b1; cpu_addr = 32'h10;
        tick(); tick();
        #1 check("rst_stall", stall, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check_counts("rst");
        cpu_rd = 1'b0;
        tick();
        rst_b = 1'b0;
        tick();

        // Cold miss with 3-cycle fill, then a hit on the same word.
        load_miss(32'h10, 3, 32'hDEADBEEF);
        load_hit(32'h10, 32'hDEADBEEF);

        // Store hit updates the line and writes through.
        store(32'h10, 32'h12345678, 2, 1'b0);
        load_hit(32'h10, 32'h12345678);

        // Store miss does not allocate; byte offset bits are ignored.
        store(32'h43, 32'hAAAA5555, 1, 1'b0);
        load_miss(32'h40, 2, 32'hAAAA5555);

        // Index conflict: 0x04 and 0x24 share a line.
        load_miss(32'h04, 1, 32'h00000404);
        load_miss(32'h24, 1, 32'h00002424);
        load_miss(32'h04, 1, 32'h00000404);

        // Load and store together behave as a store only.
        store(32'h04, 32'hCAFEF00D, 1, 1'b1);
        load_hit(32'h04, 32'hCAFEF00D);

        // Stray mem_ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1 check("idle_ack_fill", fill_we, 0);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_rdata", cpu_rdata, 0);
        tick();
        mem_ack = 1'b0;
        load_hit(32'h04, 32'hCAFEF00D);
        load_hit(32'h40, 32'hAAAA5555);
        check_counts("mid");

        // Reset during a read miss, with an ack arriving at the same time.
        cpu_rd = 1'b1; cpu_addr = 32'h08;
        tick();
        #1 check("pre_abort_req", mem_req, 1);
        rst_b = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BADF111;
        #1 check("abort_req", mem_req, 0);
        check("abort_fill", fill_we, 0);
        check("abort_stall", stall, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_rdata", cpu_rdata, 0);
        cpu_rd = 1'b0;
        tick();
        rst_b = 1'b0; mem_ack = 1'b0;
        exp_hit = 0; exp_miss = 0;
        check_counts("post_rst");
        tick();
        load_miss(32'h08, 1, 32'h00000808);
        load_miss(32'h10, 2, 32'h12345678);
        load_hit(32'h08, 32'h00000808);
        check_counts("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter LINES, default 8, number of one-word direct-mapped lines (power of two, >=2); IDX = log2(LINES).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_b  input  1  reset; one clock; reset is asynchronous and active-high (rst_b=1 resets).
REQ-005 cpu_addr  input  XLEN  MEM-stage byte address (alu result); bits [1:0] ignored.
REQ-006 cpu_wdata  input  XLEN  store data (rt value).
REQ-007 cpu_rd  input  1  load request, held while stall=1.
REQ-008 cpu_wr  input  1  store request, held while stall=1.
REQ-009 cpu_rdata  output  XLEN  load data to WB buffer.
REQ-010 stall  output  1  freezes pipeline buffers and PC.
REQ-011 fill_we  output  1  one-cycle pulse: missed load data valid on cpu_rdata (drives pipeline's cache write-enable).
REQ-012 mem_req, mem_we  output  1 each  backing-memory request / write qualifier.
REQ-013 mem_addr  output  XLEN  word-aligned address ([1:0]=0).
REQ-014 mem_wdata  output  XLEN; mem_rdata  input  XLEN; mem_ack  input  1  one-cycle completion.
REQ-015 hit_count, miss_count  output  16 each  statistics (see Configuration).

Function
REQ-016 Index = cpu_addr[IDX+1:2], tag = cpu_addr[XLEN-1:IDX+2]; each line holds valid, tag, data.
REQ-017 FSM states SHALL be IDLE, READ_MISS, WRITE_THRU.
REQ-018 IDLE, cpu_rd, hit: cpu_rdata = line data same cycle (combinational), stall=0, fill_we=0, no memory request.
REQ-019 IDLE, cpu_rd, miss: stall=1 same cycle; latch word address; next state READ_MISS.
REQ-020 READ_MISS: mem_req=1, mem_we=0, mem_addr=latched address, stall=1 until mem_ack.
REQ-021 READ_MISS with mem_ack: line written (valid=1, tag, mem_rdata), cpu_rdata=mem_rdata, fill_we=1, stall=0 that cycle, next state IDLE.
REQ-022 IDLE, cpu_wr: stall=1 same cycle; latch address/data; if hit, line data updated at that edge; if miss, cache unchanged (no write-allocate); next state WRITE_THRU.
REQ-023 WRITE_THRU: mem_req=1, mem_we=1, mem_wdata=latched data; on mem_ack stall=0 that cycle, next state IDLE.
REQ-024 cpu_rd and cpu_wr both high SHALL be treated as store only.
REQ-025 mem_ack in IDLE SHALL be ignored.
REQ-026 Request still high in the cycle after completion SHALL be treated as new access (hit for completed load).
REQ-027 mem_req SHALL stay asserted with stable address/data until mem_ack; mem_req low in IDLE.
REQ-028 cpu_rdata SHALL be 0 when no load is active.

Reset
REQ-029 rst_b=1 asynchronously: state IDLE, all valid bits 0, stall=0, fill_we=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, counters 0.
REQ-030 Reset mid-miss or mid-write SHALL abort immediately; aborted fill SHALL not update any line; first access after release is a miss.
REQ-031 Tag/data arrays need not be reset.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: hit_count increments on each IDLE load hit, miss_count on each load miss entry, both saturate at 16'hFFFF; stores counted in neither.
REQ-033 DCACHE_STATS_EN undefined: counters not built, hit_count=miss_count=0 constantly; all other behaviour identical.

Verification
REQ-034 After reset, load 0x0000_0010, mem_ack 3 cycles later with 0xDEADBEEF -> stall=1 for 3 cycles, fill_we=1 and cpu_rdata=0xDEADBEEF on ack cycle; repeat load -> hit, stall=0, same data.
REQ-035 Store 0x12345678 to 0x10 (cached) -> line updated, mem_we=1 mem_addr=0x10 until ack; load 0x10 -> hit returns 0x12345678.
REQ-036 Store to 0x40 (uncached) then load 0x40 -> store writes through, load misses (no allocate).
REQ-037 Load 0x04 then load 0x24 (LINES=8, same index, different tag) -> both miss; load 0x04 again misses (evicted).
REQ-038 rst_b pulsed during READ_MISS -> mem_req drops immediately, no fill_we; next load to same address misses.
REQ-039 With DCACHE_STATS_EN, 2 hits and 3 misses -> hit_count=2, miss_count=3; without macro both 0.
